// File: rtl/pipeid_fwd.sv
// pipeid_fwd - instruction-decode stage with operand forwarding and
// load-use hazard detection, ending in the ID/EX pipeline register.
//
// Ports
//   clk, clr            clock (rising edge) and synchronous active-high reset
//   dpc4, inst          PC+4 and instruction word held in IF/ID
//   dctrl, dwreg, dm2reg, dregrt, dsext
//                       decoded control from the control unit
//   duse_rs, duse_rt    instruction actually reads rs / rt
//   kill                squash the ID instruction into a bubble
//   ealu                result currently produced by EX
//   mrn, mwreg, mfwd    MEM-stage destination, write flag and forward value
//   wrn, wdi, wwreg     WB-stage write port into the register file
//   stall               hold PC and IF/ID this cycle (combinational)
//   rsrtequ             forwarded rs == forwarded rt (meaningful when !stall)
//   bpc, jpc            branch / jump targets (combinational)
//   ea, eb, eimm, epc4, ern, ectrl, ewreg, em2reg
//                       ID/EX register outputs seen by EX
//
// Instruction fields: op[31:26], rd[14:10], rs[9:5], rt[4:0],
// imm16[25:10], target[25:0].

module pipeid_fwd #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int CTRL_W = 12,
    parameter int FWD_EN = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [XLEN-1:0]   dpc4,
    input  logic [31:0]       inst,
    input  logic [CTRL_W-1:0] dctrl,
    input  logic              dwreg,
    input  logic              dm2reg,
    input  logic              dregrt,
    input  logic              dsext,
    input  logic              duse_rs,
    input  logic              duse_rt,
    input  logic              kill,
    input  logic [XLEN-1:0]   ealu,
    input  logic [AW-1:0]     mrn,
    input  logic              mwreg,
    input  logic [XLEN-1:0]   mfwd,
    input  logic [AW-1:0]     wrn,
    input  logic [XLEN-1:0]   wdi,
    input  logic              wwreg,
    output logic              stall,
    output logic              rsrtequ,
    output logic [XLEN-1:0]   bpc,
    output logic [XLEN-1:0]   jpc,
    output logic [XLEN-1:0]   ea,
    output logic [XLEN-1:0]   eb,
    output logic [XLEN-1:0]   eimm,
    output logic [XLEN-1:0]   epc4,
    output logic [AW-1:0]     ern,
    output logic [CTRL_W-1:0] ectrl,
    output logic              ewreg,
    output logic              em2reg
);

    // Instruction fields
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] rd;
    logic [AW-1:0] rn;
    logic          unused_op;

    assign rs = AW'(inst[9:5]);
    assign rt = AW'(inst[4:0]);
    assign rd = AW'(inst[14:10]);
    assign rn = dregrt ? rt : rd;
    // Opcode is decoded by the external control unit, not here.
    assign unused_op = ^inst[31:26];

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [XLEN-1:0] regs [NREG];
    logic [XLEN-1:0] rf_a;
    logic [XLEN-1:0] rf_b;

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wwreg && wrn != '0) begin
            regs[wrn] <= wdi;
        end
    end

    // Write-through: a WB write in this cycle is visible to this cycle's
    // read, so the WB stage never needs its own forwarding path.
    always_comb begin
        rf_a = regs[rs];
        rf_b = regs[rt];
        if (rs == '0)
            rf_a = '0;
        else if (wwreg && wrn == rs)
            rf_a = wdi;
        if (rt == '0)
            rf_b = '0;
        else if (wwreg && wrn == rt)
            rf_b = wdi;
    end

    // ------------------------------------------------------------------
    // Operand forwarding: EX beats MEM beats register file.
    // A load in EX has no data yet, so it is never a forwarding source;
    // the hazard logic stalls for that case instead.
    // ------------------------------------------------------------------
    logic            ex_fwd_ok;
    logic            mem_fwd_ok;
    logic [XLEN-1:0] fa;
    logic [XLEN-1:0] fb;

    assign ex_fwd_ok  = (FWD_EN != 0) && ewreg && !em2reg && (ern != '0);
    assign mem_fwd_ok = (FWD_EN != 0) && mwreg && (mrn != '0);

    always_comb begin
        fa = rf_a;
        if (ex_fwd_ok && ern == rs)
            fa = ealu;
        else if (mem_fwd_ok && mrn == rs)
            fa = mfwd;

        fb = rf_b;
        if (ex_fwd_ok && ern == rt)
            fb = ealu;
        else if (mem_fwd_ok && mrn == rt)
            fb = mfwd;
    end

    assign rsrtequ = (fa == fb);

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    logic ex_hit;
    logic mem_hit;
    logic stall_raw;

    assign ex_hit  = ewreg && (ern != '0) &&
                     ((duse_rs && ern == rs) || (duse_rt && ern == rt));
    assign mem_hit = mwreg && (mrn != '0) &&
                     ((duse_rs && mrn == rs) || (duse_rt && mrn == rt));

    // With forwarding only a load in EX is a hazard; without it every
    // RAW against EX or MEM waits until the producer reaches WB.
    assign stall_raw = (FWD_EN != 0) ? (ex_hit && em2reg) : (ex_hit || mem_hit);
    assign stall     = stall_raw && !clr;

    // ------------------------------------------------------------------
    // Immediate and control-flow targets
    // ------------------------------------------------------------------
    logic            sext_bit;
    logic [XLEN-1:0] imm;

    assign sext_bit = dsext & inst[25];
    assign imm      = {{(XLEN-16){sext_bit}}, inst[25:10]};
    assign bpc      = dpc4 + {imm[XLEN-3:0], 2'b00};
    assign jpc      = {dpc4[XLEN-1:28], inst[25:0], 2'b00};

    // ------------------------------------------------------------------
    // ID/EX pipeline register. A bubble is an all-zero entry so EX sees
    // no write, no load and no destination.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr || kill || stall) begin
            ea     <= '0;
            eb     <= '0;
            eimm   <= '0;
            epc4   <= '0;
            ern    <= '0;
            ectrl  <= '0;
            ewreg  <= 1'b0;
            em2reg <= 1'b0;
        end else begin
            ea     <= fa;
            eb     <= fb;
            eimm   <= imm;
            epc4   <= dpc4;
            ern    <= rn;
            ectrl  <= dctrl;
            ewreg  <= dwreg;
            em2reg <= dm2reg;
        end
    end

endmodule

// File: tb/tb_pipeid_fwd.sv
// tb_pipeid_fwd - directed test of pipeid_fwd. One instance with full
// forwarding, one with forwarding disabled; both share all inputs.

module tb_pipeid_fwd;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int CW   = 12;

    logic            clk = 1'b0;
    logic            clr;
    logic [XLEN-1:0] dpc4;
    logic [31:0]     inst;
    logic [CW-1:0]   dctrl;
    logic            dwreg, dm2reg, dregrt, dsext, duse_rs, duse_rt, kill;
    logic [XLEN-1:0] ealu, mfwd, wdi;
    logic [AW-1:0]   mrn, wrn;
    logic            mwreg, wwreg;

    // full-forwarding instance outputs
    logic            stall, rsrtequ, ewreg, em2reg;
    logic [XLEN-1:0] bpc, jpc, ea, eb, eimm, epc4;
    logic [AW-1:0]   ern;
    logic [CW-1:0]   ectrl;

    // no-forwarding instance outputs
    logic            stall_n, rsrtequ_n, ewreg_n, em2reg_n;
    logic [XLEN-1:0] bpc_n, jpc_n, ea_n, eb_n, eimm_n, epc4_n;
    logic [AW-1:0]   ern_n;
    logic [CW-1:0]   ectrl_n;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipeid_fwd #(.XLEN(XLEN), .NREG(32), .CTRL_W(CW), .FWD_EN(1)) u_f (
        .clk(clk), .clr(clr), .dpc4(dpc4), .inst(inst), .dctrl(dctrl),
        .dwreg(dwreg), .dm2reg(dm2reg), .dregrt(dregrt), .dsext(dsext),
        .duse_rs(duse_rs), .duse_rt(duse_rt), .kill(kill), .ealu(ealu),
        .mrn(mrn), .mwreg(mwreg), .mfwd(mfwd), .wrn(wrn), .wdi(wdi),
        .wwreg(wwreg), .stall(stall), .rsrtequ(rsrtequ), .bpc(bpc),
        .jpc(jpc), .ea(ea), .eb(eb), .eimm(eimm), .epc4(epc4), .ern(ern),
        .ectrl(ectrl), .ewreg(ewreg), .em2reg(em2reg)
    );

    pipeid_fwd #(.XLEN(XLEN), .NREG(32), .CTRL_W(CW), .FWD_EN(0)) u_n (
        .clk(clk), .clr(clr), .dpc4(dpc4), .inst(inst), .dctrl(dctrl),
        .dwreg(dwreg), .dm2reg(dm2reg), .dregrt(dregrt), .dsext(dsext),
        .duse_rs(duse_rs), .duse_rt(duse_rt), .kill(kill), .ealu(ealu),
        .mrn(mrn), .mwreg(mwreg), .mfwd(mfwd), .wrn(wrn), .wdi(wdi),
        .wwreg(wwreg), .stall(stall_n), .rsrtequ(rsrtequ_n), .bpc(bpc_n),
        .jpc(jpc_n), .ea(ea_n), .eb(eb_n), .eimm(eimm_n), .epc4(epc4_n),
        .ern(ern_n), .ectrl(ectrl_n), .ewreg(ewreg_n), .em2reg(em2reg_n)
    );

    // ---------------- driver helpers ----------------
    function automatic logic [31:0] mk(input logic [4:0] rd_f,
                                       input logic [4:0] rs_f,
                                       input logic [4:0] rt_f);
        return {6'b0, 11'b0, rd_f, rs_f, rt_f};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        inst = 32'h0; dctrl = '0; dpc4 = '0;
        dwreg = 0; dm2reg = 0; dregrt = 0; dsext = 0;
        duse_rs = 0; duse_rt = 0; kill = 0;
        ealu = '0; mfwd = '0; mrn = '0; mwreg = 0;
        wdi = '0; wrn = '0; wwreg = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        set_nop();
        clr = 1;
        inst = 32'hFFFF_FFFF; dctrl = 12'hFFF; dpc4 = 32'h1234_5678;
        dwreg = 1; dm2reg = 1; dsext = 1; duse_rs = 1; duse_rt = 1;
        tick(); tick();
        n_checks++; if (ewreg !== 1'b0 || em2reg !== 1'b0 || ern !== '0) begin
            n_fail++; $display("FAIL reset_flags: ewreg=%b em2reg=%b ern=%0d, want 0", ewreg, em2reg, ern); end
        n_checks++; if (ea !== '0 || eb !== '0 || eimm !== '0 || epc4 !== '0 || ectrl !== '0) begin
            n_fail++; $display("FAIL reset_data: ea=%h eb=%h eimm=%h epc4=%h ectrl=%h, want 0", ea, eb, eimm, epc4, ectrl); end
        n_checks++; if (stall !== 1'b0 || stall_n !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall: stall=%b stall_n=%b, want 0", stall, stall_n); end
        n_checks++; if (ewreg_n !== 1'b0) begin
            n_fail++; $display("FAIL reset_nofwd: ewreg_n=%b, want 0", ewreg_n); end
        clr = 0;
        set_nop();
        inst = mk(5'd0, 5'd5, 5'd0); duse_rs = 1;
        tick();
        n_checks++; if (ea !== 32'h0) begin
            n_fail++; $display("FAIL reset_r5: ea=%h, want 00000000", ea); end
    endtask

    task automatic test_regfile_bypass();
        set_nop();
        wwreg = 1; wrn = 5'd3; wdi = 32'h1234;
        inst = mk(5'd0, 5'd3, 5'd0); duse_rs = 1;
        #1;
        n_checks++; if (stall !== 1'b0) begin
            n_fail++; $display("FAIL wb_bypass_stall: stall=%b, want 0", stall); end
        tick();
        n_checks++; if (ea !== 32'h0000_1234) begin
            n_fail++; $display("FAIL wb_bypass: ea=%h, want 00001234", ea); end
        wrn = 5'd0; wdi = 32'hFFFF;
        inst = mk(5'd0, 5'd0, 5'd0);
        tick();
        n_checks++; if (ea !== 32'h0) begin
            n_fail++; $display("FAIL r0_write: ea=%h, want 00000000", ea); end
        wwreg = 0;
        inst = mk(5'd0, 5'd3, 5'd0);
        tick();
        n_checks++; if (ea !== 32'h0000_1234) begin
            n_fail++; $display("FAIL r3_stored: ea=%h, want 00001234", ea); end
    endtask

    task automatic test_ex_mem_fwd();
        set_nop();
        inst = mk(5'd4, 5'd0, 5'd0); dwreg = 1;
        tick();
        n_checks++; if (ern !== 5'd4 || ewreg !== 1'b1) begin
            n_fail++; $display("FAIL alu_into_ex: ern=%0d ewreg=%b, want 4/1", ern, ewreg); end
        dwreg = 0;
        inst = mk(5'd0, 5'd4, 5'd0); duse_rs = 1;
        ealu = 32'hA5; mwreg = 1; mrn = 5'd4; mfwd = 32'h77;
        #1;
        n_checks++; if (stall !== 1'b0) begin
            n_fail++; $display("FAIL ex_fwd_stall: stall=%b, want 0", stall); end
        tick();
        n_checks++; if (ea !== 32'hA5) begin
            n_fail++; $display("FAIL ex_over_mem: ea=%h, want 000000a5", ea); end
        // EX now holds a non-writing instruction; MEM still owns r4.
        inst = mk(5'd0, 5'd0, 5'd4); duse_rs = 0; duse_rt = 1;
        #1;
        n_checks++; if (rsrtequ !== 1'b0) begin
            n_fail++; $display("FAIL rsrtequ_ne: rsrtequ=%b, want 0", rsrtequ); end
        tick();
        n_checks++; if (eb !== 32'h77) begin
            n_fail++; $display("FAIL mem_fwd: eb=%h, want 00000077", eb); end
        inst = mk(5'd0, 5'd4, 5'd4); duse_rs = 1;
        #1;
        n_checks++; if (rsrtequ !== 1'b1) begin
            n_fail++; $display("FAIL rsrtequ_eq: rsrtequ=%b, want 1", rsrtequ); end
        tick();
    endtask

    task automatic test_load_use();
        set_nop();
        tick();
        inst = mk(5'd0, 5'd0, 5'd7); dwreg = 1; dm2reg = 1; dregrt = 1;
        tick();
        n_checks++; if (ern !== 5'd7 || em2reg !== 1'b1) begin
            n_fail++; $display("FAIL load_into_ex: ern=%0d em2reg=%b, want 7/1", ern, em2reg); end
        inst = mk(5'd8, 5'd0, 5'd7); dwreg = 1; dm2reg = 0; dregrt = 0; duse_rt = 1;
        ealu = 32'hDEAD;
        #1;
        n_checks++; if (stall !== 1'b1) begin
            n_fail++; $display("FAIL load_use_stall: stall=%b, want 1", stall); end
        tick();
        n_checks++; if (ewreg !== 1'b0 || ern !== '0 || eb !== '0) begin
            n_fail++; $display("FAIL load_use_bubble: ewreg=%b ern=%0d eb=%h, want 0", ewreg, ern, eb); end
        mrn = 5'd7; mwreg = 1; mfwd = 32'hBEEF;
        #1;
        n_checks++; if (stall !== 1'b0) begin
            n_fail++; $display("FAIL load_use_release: stall=%b, want 0", stall); end
        tick();
        n_checks++; if (eb !== 32'hBEEF || ern !== 5'd8 || ewreg !== 1'b1) begin
            n_fail++; $display("FAIL load_use_retry: eb=%h ern=%0d ewreg=%b, want 0000beef/8/1", eb, ern, ewreg); end
    endtask

    task automatic test_imm_targets();
        set_nop();
        tick();
        inst = 32'h03FF_FC00; dsext = 1; dpc4 = 32'h100;
        #1;
        n_checks++; if (bpc !== 32'h0000_00FC) begin
            n_fail++; $display("FAIL bpc_neg: bpc=%h, want 000000fc", bpc); end
        tick();
        n_checks++; if (eimm !== 32'hFFFF_FFFF || epc4 !== 32'h100) begin
            n_fail++; $display("FAIL eimm_sext: eimm=%h epc4=%h, want ffffffff/00000100", eimm, epc4); end
        dsext = 0;
        #1;
        n_checks++; if (bpc !== 32'h0004_00FC) begin
            n_fail++; $display("FAIL bpc_zext: bpc=%h, want 000400fc", bpc); end
        tick();
        n_checks++; if (eimm !== 32'h0000_FFFF) begin
            n_fail++; $display("FAIL eimm_zext: eimm=%h, want 0000ffff", eimm); end
        inst = 32'h0000_0040; dpc4 = 32'h4000_0004;
        #1;
        n_checks++; if (jpc !== 32'h4000_0100) begin
            n_fail++; $display("FAIL jpc: jpc=%h, want 40000100", jpc); end
    endtask

    task automatic test_kill();
        set_nop();
        inst = mk(5'd9, 5'd0, 5'd0); dwreg = 1; dctrl = 12'hABC; kill = 1;
        tick();
        n_checks++; if (ewreg !== 1'b0 || ectrl !== '0 || ern !== '0) begin
            n_fail++; $display("FAIL kill_bubble: ewreg=%b ectrl=%h ern=%0d, want 0", ewreg, ectrl, ern); end
        kill = 0;
        tick();
        n_checks++; if (ectrl !== 12'hABC || ern !== 5'd9 || ewreg !== 1'b1) begin
            n_fail++; $display("FAIL after_kill: ectrl=%h ern=%0d ewreg=%b, want abc/9/1", ectrl, ern, ewreg); end
        // kill together with a load-use stall
        inst = mk(5'd0, 5'd0, 5'd10); dctrl = '0; dwreg = 1; dm2reg = 1; dregrt = 1;
        tick();
        inst = mk(5'd12, 5'd10, 5'd0); dm2reg = 0; dregrt = 0; duse_rs = 1; kill = 1;
        #1;
        n_checks++; if (stall !== 1'b1) begin
            n_fail++; $display("FAIL kill_stall_flag: stall=%b, want 1", stall); end
        tick();
        n_checks++; if (ewreg !== 1'b0 || ern !== '0) begin
            n_fail++; $display("FAIL kill_stall_bubble: ewreg=%b ern=%0d, want 0", ewreg, ern); end
        kill = 0;
        // reset arriving during a stall
        inst = mk(5'd0, 5'd0, 5'd11); duse_rs = 0; dm2reg = 1; dregrt = 1;
        tick();
        inst = mk(5'd12, 5'd11, 5'd0); dm2reg = 0; dregrt = 0; duse_rs = 1;
        #1;
        n_checks++; if (stall !== 1'b1) begin
            n_fail++; $display("FAIL pre_clr_stall: stall=%b, want 1", stall); end
        clr = 1;
        #1;
        n_checks++; if (stall !== 1'b0) begin
            n_fail++; $display("FAIL clr_masks_stall: stall=%b, want 0", stall); end
        tick();
        clr = 0;
        #1;
        n_checks++; if (ewreg !== 1'b0 || ern !== '0 || stall !== 1'b0) begin
            n_fail++; $display("FAIL clr_mid_stall: ewreg=%b ern=%0d stall=%b, want 0", ewreg, ern, stall); end
    endtask

    task automatic test_nofwd();
        set_nop();
        tick(); tick();
        inst = mk(5'd2, 5'd0, 5'd0); dwreg = 1;
        tick();
        inst = mk(5'd0, 5'd2, 5'd0); dwreg = 0; duse_rs = 1; ealu = 32'h55;
        #1;
        n_checks++; if (stall_n !== 1'b1) begin
            n_fail++; $display("FAIL nofwd_stall_ex: stall_n=%b, want 1", stall_n); end
        tick();
        n_checks++; if (ewreg_n !== 1'b0) begin
            n_fail++; $display("FAIL nofwd_bubble1: ewreg_n=%b, want 0", ewreg_n); end
        mrn = 5'd2; mwreg = 1; mfwd = 32'h66;
        #1;
        n_checks++; if (stall_n !== 1'b1) begin
            n_fail++; $display("FAIL nofwd_stall_mem: stall_n=%b, want 1", stall_n); end
        tick();
        mwreg = 0; mrn = '0;
        wrn = 5'd2; wwreg = 1; wdi = 32'h2222;
        #1;
        n_checks++; if (stall_n !== 1'b0) begin
            n_fail++; $display("FAIL nofwd_release: stall_n=%b, want 0", stall_n); end
        tick();
        n_checks++; if (ea_n !== 32'h2222) begin
            n_fail++; $display("FAIL nofwd_value: ea_n=%h, want 00002222", ea_n); end
        wwreg = 0; wrn = '0;
        inst = mk(5'd6, 5'd0, 5'd0); duse_rs = 0; dwreg = 1; kill = 1;
        tick();
        n_checks++; if (ewreg_n !== 1'b0) begin
            n_fail++; $display("FAIL nofwd_kill: ewreg_n=%b, want 0", ewreg_n); end
        kill = 0;
    endtask

    initial begin
        set_nop();
        clr = 1;
        test_reset();
        test_regfile_bypass();
        test_ex_mem_fwd();
        test_load_use();
        test_imm_targets();
        test_kill();
        test_nofwd();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeid_fwd.md
Name: pipeid_fwd

Overview:
- Parametrised, hazard-aware successor to the pipelined CPU's instruction-decode stage.
- Holds the register file, builds the immediate and the branch/jump targets, forwards operands from EX/MEM/WB, and detects load-use hazards, stalling IF/ID when one occurs.
- Owns the ID/EX pipeline register, so EX sees registered operands and control.
- Sits between the IF/ID register and the EX stage; the existing control unit supplies decoded control.

Parameters:
XLEN, 32, datapath width; must be >= 32
NREG, 32, register count (power of 2); AW = log2(NREG)
CTRL_W, 12, width of opaque control bundle passed ID->EX
FWD_EN, 1, 1 = full forwarding; 0 = no EX/MEM forwarding, stall on every RAW instead

Ports:
clk  in  1  clock, all state on rising edge
clr  in  1  reset, synchronous, active-high
dpc4  in  XLEN  PC+4 of ID instruction
inst  in  32  ID instruction; op[31:26], rd[14:10], rs[9:5], rt[4:0], imm16[25:10], target[25:0]
dctrl  in  CTRL_W  decoded control from control unit
dwreg, dm2reg, dregrt, dsext  in  1 each  decoded write-reg, load, dest=rt, sign-extend
duse_rs, duse_rt  in  1 each  instruction reads rs / rt
kill  in  1  squash ID instruction into bubble
ealu  in  XLEN  EX-stage result
mrn  in  AW  MEM destination
mwreg  in  1  MEM writes register
mfwd  in  XLEN  MEM forward value (load data or ALU result, selected in MEM)
wrn  in  AW  WB destination
wdi  in  XLEN  WB data
wwreg  in  1  WB write enable
stall  out  1  hold PC and IF/ID (combinational)
rsrtequ  out  1  forwarded rs == forwarded rt (combinational)
bpc, jpc  out  XLEN  branch / jump targets (combinational)
ea, eb, eimm, epc4  out  XLEN  registered operands, immediate, PC+4
ern  out  AW  registered destination
ectrl  out  CTRL_W  registered control
ewreg, em2reg  out  1  registered write-reg / load flags

Behaviour:
- Register file, NREG x XLEN:
  - Written on rising clk when wwreg && wrn!=0.
  - Register 0 always reads 0.
  - clr zeroes every entry.
  - Same-cycle read of wrn returns wdi (write-through bypass).
- Operand select for rs (rt identical), highest priority first:
  - If FWD_EN && ewreg && !em2reg && ern!=0 && ern==rs, select ealu.
  - Else if FWD_EN && mwreg && mrn!=0 && mrn==rs, select mfwd.
  - Else select the register file output, which includes the WB bypass.
- Stall, FWD_EN=1: stall=1 if ewreg && em2reg && ern!=0 && ((duse_rs && ern==rs) || (duse_rt && ern==rt)).
- Stall, FWD_EN=0: stall=1 on any used-source match with EX (ewreg, ern!=0) or with MEM (mwreg, mrn!=0).
- Stall is forced to 0 while clr=1.
- Immediate: e = dsext & inst[25]; imm = {(XLEN-16){e}, inst[25:10]}.
- bpc = dpc4 + (imm<<2), modulo 2^XLEN; no overflow flag.
- jpc = {dpc4[XLEN-1:28], inst[25:0], 2'b00}.
- rn = dregrt ? rt : rd.
- rsrtequ uses the forwarded values; it is valid only when stall=0.
- ID/EX register, per rising edge, in priority order:
  - clr: all outputs 0.
  - else if kill || stall: bubble. ectrl, ewreg, em2reg, ern, ea, eb, eimm, epc4 all 0.
  - else: load the forwarded operands, imm, dpc4, rn, dctrl, dwreg, dm2reg.
- kill and stall together: one bubble; stall output still asserted.
- Reset values: all registered outputs 0, all registers 0.
- Reset mid-stall: next cycle the pipeline is empty and stall=0.
- Latency: one cycle ID to EX; a load-use stall costs exactly one bubble.

Test Plan:
- clr=1 for 2 cycles -> all E-outputs 0; stall=0; reading r5 returns 0.
- WB writes r3=0x1234 while ID reads rs=3 in the same cycle -> ea=0x00001234 next edge; a write to r0 (wrn=0, wdi=0xFFFF) -> r0 still reads 0.
- ALU op r4=…, next instruction uses rs=4 with ealu=0xA5 -> ea=0xA5, stall=0; a MEM match with mfwd=0x77 in the same cycle loses to EX.
- Load to r7, next instruction uses rt=7 -> stall=1 for exactly one cycle, one bubble (ewreg=0) enters ID/EX; on the retry eb=mfwd.
- dsext=1, inst[25:10]=0xFFFF, dpc4=0x100 -> eimm=0xFFFFFFFF and bpc=0xFC; jpc for target 0x0000040 with dpc4=0x40000004 -> 0x40000100.
- FWD_EN=0: ALU write r2 then read r2 -> stall held 2 cycles until the value reaches WB, then ea is correct; kill asserted in a normal cycle -> bubble with ewreg=0.
